miriscv_dmem_arbiter: RTL and testbench
=======================================

MIRISCV_DMEM_ARBITER -- requirements
Module: miriscv_dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: BUSY cycles without mem_ready_i before a transaction is aborted with an error (legal range 1..1023).
REQ-002 clk_i  input  1  sole clock; every register updates on its rising edge.
REQ-003 arstn_i  input  1  reset; synchronous, active-high.
REQ-004 m0_req_i / m1_req_i  input  1  requester N transaction request; port 0 is the LSU, port 1 is the secondary master.
REQ-005 m0_we_i / m1_we_i  input  1  requester N write enable.
REQ-006 m0_be_i / m1_be_i  input  4  requester N byte enables.
REQ-007 m0_addr_i / m1_addr_i  input  32  requester N byte address.
REQ-008 m0_wdata_i / m1_wdata_i  input  32  requester N write data.
REQ-009 m0_rdata_o / m1_rdata_o  output  32  read data returned to requester N.
REQ-010 m0_ready_o / m1_ready_o  output  1  one-cycle completion pulse to requester N.
REQ-011 m0_err_o / m1_err_o  output  1  one-cycle timeout-error pulse to requester N, coincident with ready.
REQ-012 m0_stall_o / m1_stall_o  output  1  requester N is held: mN_req_i high and mN_ready_o low.
REQ-013 data_req_o, data_we_o  output  1 each  memory request and write enable.
REQ-014 data_be_o  output  4; data_addr_o, data_wdata_o  output  32 each  memory byte enables, address and write data.
REQ-015 data_rdata_i  input  32; mem_ready_i  input  1  memory read data and completion.

Function
REQ-016 The FSM SHALL have two states: IDLE and BUSY.
REQ-017 IDLE: if any mN_req_i is high, the block SHALL select a winner, latch its we/be/addr/wdata and the owner index, and enter BUSY on the next edge; otherwise it stays in IDLE.
REQ-018 BUSY: data_req_o SHALL be 1 and data_we_o, data_be_o, data_addr_o and data_wdata_o SHALL come from the latched registers, stable until completion.
REQ-019 IDLE: data_req_o SHALL be 0, data_be_o SHALL be 0 and the remaining memory outputs SHALL be 0.
REQ-020 BUSY with mem_ready_i=1: the owner's ready_o SHALL be 1 combinationally in that cycle, its rdata_o SHALL equal data_rdata_i, and the FSM SHALL return to IDLE.
REQ-021 Minimum latency SHALL be 2 cycles from request to ready (request sampled in IDLE, ready in the first BUSY cycle); a one-cycle IDLE bubble SHALL separate back-to-back transactions.
REQ-022 The non-owner's ready_o and err_o SHALL be 0 and its rdata_o SHALL be 0 at all times.
REQ-023 A timeout counter SHALL clear on entry to BUSY and increment in each BUSY cycle with mem_ready_i=0.
REQ-024 When the counter reaches TIMEOUT_CYCLES, the owner's ready_o and err_o SHALL pulse together with rdata_o=0, and the FSM SHALL return to IDLE.
REQ-025 If mem_ready_i=1 in the same cycle the timeout is reached, the response SHALL be a normal completion with no error.
REQ-026 A requester deasserting req during BUSY SHALL NOT abort the transaction; the response is still issued.
REQ-027 A requester holding req in the cycle after its ready pulse SHALL be treated as a new request.
REQ-028 A last_grant register SHALL record the owner index each time a grant is made.

Reset
REQ-029 With arstn_i=1 at a rising edge: FSM to IDLE, counter to 0, latched fields to 0, last_grant to 1.
REQ-030 During reset and in the cycle after it, all outputs SHALL be 0, except that stall_o follows REQ-012.
REQ-031 A reset asserted during BUSY SHALL discard the transaction with no ready or err pulse.

Configuration
REQ-032 With macro MIRISCV_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port other than last_grant; a single request SHALL be granted directly.
REQ-033 Without MIRISCV_ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (fixed priority) and last_grant SHALL be unused.

Structure
REQ-034 The arb_state_t enum (IDLE, BUSY) and the ARB_PORTS=2 constant SHALL live in riscv_pkg.
REQ-035 Winner selection SHALL be a sub-module miriscv_rr_arbiter (inputs: req vector, last_grant; output: one-hot grant).

Verification
REQ-036 m0 read of addr 0x100 with mem_ready_i high in the first BUSY cycle and data_rdata_i=0xDEADBEEF -> m0_ready_o pulses on cycle 2 with m0_rdata_o=0xDEADBEEF; m1 outputs stay 0.
REQ-037 m0 and m1 request on the same cycle, round-robin build -> m0 served first, then m1; with m0 still requesting, the next grant goes to m1, so grants alternate m0, m1, m0, m1.
REQ-038 Same stimulus on the fixed-priority build -> m1 is stalled for as long as m0 keeps requesting.
REQ-039 m1 write of 0xA5 with be=0100 at addr 0x203 and mem_ready_i delayed 3 cycles -> data_addr_o, data_be_o and data_wdata_o stay stable for all 3 cycles; m1_stall_o is high until the ready pulse.
REQ-040 TIMEOUT_CYCLES=4 with mem_ready_i held at 0 -> m0_ready_o and m0_err_o pulse 4 BUSY cycles after entry with rdata 0; the FSM returns to IDLE.
REQ-041 arstn_i pulsed during BUSY -> no ready pulse, data_req_o=0 on the next cycle, and the first grant after reset goes to m0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the MIRISCV data-memory arbiter.
package riscv_pkg;

  localparam int unsigned ARB_PORTS    = 2;
  // Wide enough for the largest supported timeout (1023).
  localparam int unsigned ARB_TO_CNT_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// miriscv_rr_arbiter: picks the winner among the two data-memory requesters.
// MIRISCV_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to the
// port that did not win last; otherwise port 0 always wins ties.
module miriscv_rr_arbiter
  import riscv_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req_i,
  input  logic                 last_grant_i,
  output logic [ARB_PORTS-1:0] grant_o
);

`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
  // Tie goes to the port other than the previous winner.
  always_comb begin
    grant_o = '0;
    if (req_i[0] && req_i[1]) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end
`else
  // Fixed priority: history is not needed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Tie always goes to port 0 (the LSU).
  always_comb begin
    grant_o = '0;
    if (req_i[0] && req_i[1]) begin
      grant_o = 2'b01;
    end else begin
      grant_o = req_i;
    end
  end
`endif

endmodule

// File: rtl/miriscv_dmem_arbiter.sv
// miriscv_dmem_arbiter: two-master arbiter in front of a single data memory
// port, one outstanding transaction at a time, with a BUSY timeout.
// MIRISCV_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: port 0 wins).
module miriscv_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        arstn_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  output logic        m0_stall_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        m1_stall_o,

  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [ARB_TO_CNT_W-1:0] TO_LIMIT = ARB_TO_CNT_W'(TIMEOUT_CYCLES);

  arb_state_t              state_q, state_d;
  logic [ARB_TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [ARB_PORTS-1:0]    req;
  logic [ARB_PORTS-1:0]    grant;
  logic                    timeout_hit;
  logic                    done;
  logic                    timeout_err;

  assign req = {m1_req_i, m0_req_i};

  miriscv_rr_arbiter u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // A ready from memory in the timeout cycle wins over the timeout.
  assign timeout_hit = (cnt_q == TO_LIMIT);
  assign done        = mem_ready_i || timeout_hit;
  assign timeout_err = timeout_hit && !mem_ready_i;

  // State register and latched transaction fields.
  always_ff @(posedge clk_i) begin
    if (arstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next state: grant and latch in IDLE, count or complete in BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d      = BUSY;
          cnt_d        = '0;
          owner_d      = grant[1];
          last_grant_d = grant[1];
          we_d         = grant[1] ? m1_we_i    : m0_we_i;
          be_d         = grant[1] ? m1_be_i    : m0_be_i;
          addr_d       = grant[1] ? m1_addr_i  : m0_addr_i;
          wdata_d      = grant[1] ? m1_wdata_i : m0_wdata_i;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory side from latched fields, response routed to the owner only.
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    m0_ready_o   = 1'b0;
    m0_err_o     = 1'b0;
    m0_rdata_o   = '0;
    m1_ready_o   = 1'b0;
    m1_err_o     = 1'b0;
    m1_rdata_o   = '0;
    if (!arstn_i && state_q == BUSY) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be_q;
      data_addr_o  = addr_q;
      data_wdata_o = wdata_q;
      if (owner_q) begin
        m1_ready_o = done;
        m1_err_o   = timeout_err;
        m1_rdata_o = mem_ready_i ? data_rdata_i : '0;
      end else begin
        m0_ready_o = done;
        m0_err_o   = timeout_err;
        m0_rdata_o = mem_ready_i ? data_rdata_i : '0;
      end
    end
  end

  assign m0_stall_o = m0_req_i && !m0_ready_o;
  assign m1_stall_o = m1_req_i && !m1_ready_o;

endmodule

// File: tb/tb_miriscv_dmem_arbiter.sv
// tb_miriscv_dmem_arbiter: scoreboard bench. Stimulus decides each winner from
// the arbitration rules and queues the expected response and memory-side view;
// a memory responder and a response monitor check the DUT independently.
module tb_miriscv_dmem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ready_o, m0_err_o, m0_stall_o;
  logic        m1_ready_o, m1_err_o, m1_stall_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        mem_ready_i;

  miriscv_dmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;   // BUSY cycles before memory answers
  } txn_t;

  txn_t plan_q[$];
  txn_t exp_q[$];
  txn_t pend_t[2];
  bit   pend[2];
  int   last_w;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s at %0t", nm, what, $time);
  endtask

  // Cycle index at which the owner must see its response.
  function automatic int resp_idx(input int lat);
    return (lat < int'(TO)) ? lat : int'(TO);
  endfunction

  // Arbitration rule applied to the set of pending requesters.
  function automatic int pick();
    if (pend[0] && pend[1]) begin
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
      return 1 - last_w;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic drive();
    m0_req_i = pend[0]; m0_we_i = pend_t[0].we; m0_be_i = pend_t[0].be;
    m0_addr_i = pend_t[0].addr; m0_wdata_i = pend_t[0].wdata;
    m1_req_i = pend[1]; m1_we_i = pend_t[1].we; m1_be_i = pend_t[1].be;
    m1_addr_i = pend_t[1].addr; m1_wdata_i = pend_t[1].wdata;
  endtask

  task automatic new_txn(input int p);
    pend_t[p] = '{port: p, we: 1'($urandom_range(0, 1)), be: 4'($urandom),
                  addr: $urandom, wdata: $urandom, rdata: '0, lat: 0};
    pend[p] = 1'b1;
  endtask

  task automatic push_plan(input int w, input int lat, input logic [31:0] rd);
    txn_t t;
    t = pend_t[w];
    t.port = w;
    t.lat = lat;
    t.rdata = rd;
    plan_q.push_back(t);
    exp_q.push_back(t);
    last_w = w;
  endtask

  // Issue the winner's transaction and wait (bounded) for its ready pulse.
  task automatic serve(input int w, input int lat, input logic [31:0] rd);
    bit got;
    push_plan(w, lat, rd);
    drive();
    got = 1'b0;
    for (int i = 0; i < int'(TO) + 8; i++) begin
      tick();
      if ((w == 1) ? m1_ready_o : m0_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("ready_wait", "no ready pulse, required one");
    pend[w] = 1'b0;
    drive();
  endtask

  task automatic rand_round(input int pct);
    for (int p = 0; p < 2; p++)
      if (!pend[p] && $urandom_range(0, 99) < pct) new_txn(p);
    if (!pend[0] && !pend[1]) new_txn(int'($urandom_range(0, 1)));
    serve(pick(), int'($urandom_range(0, TO + 2)), $urandom);
  endtask

  // Memory responder: answers each granted transaction after its planned
  // latency and checks the memory-side signals against the plan.
  initial begin : mem_model
    txn_t cur;
    bit   active;
    int   k;
    active = 1'b0;
    k = 0;
    mem_ready_i = 1'b0;
    data_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (arstn_i) begin
        active = 1'b0;
        mem_ready_i = 1'b0;
      end else begin
        if (!active && data_req_o) begin
          if (plan_q.size() == 0) fail("mem_req", "unexpected memory request");
          else begin
            cur = plan_q.pop_front();
            active = 1'b1;
            k = 0;
          end
        end
        if (active && k <= resp_idx(cur.lat)) begin
          chk("mem_req_busy", 32'(data_req_o), 32'd1);
          chk("mem_we", 32'(data_we_o), 32'(cur.we));
          chk("mem_be", 32'(data_be_o), 32'(cur.be));
          chk("mem_addr", data_addr_o, cur.addr);
          chk("mem_wdata", data_wdata_o, cur.wdata);
          mem_ready_i = (k == cur.lat);
          data_rdata_i = (k == cur.lat) ? cur.rdata : $urandom;
          k++;
        end else begin
          mem_ready_i = 1'b0;
          data_rdata_i = $urandom;
          if (active) begin
            chk("mem_bubble", 32'(data_req_o), 32'd0);
            active = 1'b0;
          end
          if (!data_req_o)
            chk("mem_idle_zero", {data_addr_o ^ 32'd0} | data_wdata_o | 32'(data_be_o) | 32'(data_we_o), 32'd0);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a ready pulse appears.
  initial begin : resp_monitor
    txn_t t;
    int   own;
    logic r, e, rq, st;
    logic [31:0] d;
    forever begin
      @(negedge clk_i);
      own = (exp_q.size() > 0) ? exp_q[0].port : -1;
      for (int p = 0; p < 2; p++) begin
        r  = (p == 1) ? m1_ready_o : m0_ready_o;
        e  = (p == 1) ? m1_err_o   : m0_err_o;
        d  = (p == 1) ? m1_rdata_o : m0_rdata_o;
        rq = (p == 1) ? m1_req_i   : m0_req_i;
        st = (p == 1) ? m1_stall_o : m0_stall_o;
        chk("stall", 32'(st), 32'(rq && !r));
        if (r) begin
          if (exp_q.size() == 0) fail("resp", "ready pulse with nothing outstanding");
          else begin
            t = exp_q.pop_front();
            chk("resp_port", p, t.port);
            chk("resp_err", 32'(e), (t.lat > int'(TO)) ? 32'd1 : 32'd0);
            chk("resp_rdata", d, (t.lat > int'(TO)) ? 32'd0 : t.rdata);
          end
        end else begin
          chk("err_no_ready", 32'(e), 32'd0);
          if (p != own) chk("nonowner_rdata", d, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    new_txn(0); new_txn(1);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    last_w = 1;
    arstn_i = 1'b1;
    repeat (3) tick();
    chk("rst_data_req", 32'(data_req_o), 32'd0);
    arstn_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_zero", 32'(data_req_o) | 32'(data_be_o) | data_addr_o | data_wdata_o |
        32'(m0_ready_o) | 32'(m1_ready_o) | 32'(m0_err_o) | 32'(m1_err_o) |
        m0_rdata_o | m1_rdata_o, 32'd0);
    #2;

    // m0 read of 0x100, memory answers immediately.
    pend_t[0] = '{port: 0, we: 1'b0, be: 4'hF, addr: 32'h100, wdata: '0, rdata: '0, lat: 0};
    pend[0] = 1'b1;
    serve(pick(), 0, 32'hDEADBEEF);

    // m1 byte write at 0x203, memory answers in the fourth BUSY cycle.
    pend_t[1] = '{port: 1, we: 1'b1, be: 4'b0100, addr: 32'h203, wdata: 32'hA5, rdata: '0, lat: 0};
    pend[1] = 1'b1;
    serve(pick(), 3, $urandom);

    // Memory never answers: timeout, then the exact boundary case.
    new_txn(0);
    serve(pick(), int'(TO) + 2, $urandom);
    new_txn(1);
    serve(pick(), int'(TO), $urandom);

    // Both masters keep requesting.
    for (int i = 0; i < 6; i++) rand_round(100);
    for (int i = 0; i < 80; i++) rand_round(60);

    // Reset in the middle of a transaction.
    if (!pend[0]) new_txn(0);
    push_plan(pick(), int'(TO) + 2, $urandom);
    drive();
    tick();
    tick();
    arstn_i = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    exp_q.delete();
    plan_q.delete();
    @(negedge clk_i);
    chk("rst_busy_data_req", 32'(data_req_o), 32'd0);
    #2;
    arstn_i = 1'b0;
    last_w = 1;
    new_txn(0);
    new_txn(1);
    serve(pick(), 1, $urandom);
    for (int i = 0; i < 4; i++) rand_round(100);

    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (4) tick();
    chk("exp_left", exp_q.size(), 32'd0);
    chk("plan_left", plan_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
